// File: rtl/io_input_debounce.sv
// Switch/key input conditioning: 2-FF synchronizers, per-bit stability-counter
// debouncers, key press events and 8-bit press counters packed into 32-bit port words.
module io_input_debounce #(
  parameter int N_SW      = 18,
  parameter int N_KEY     = 4,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw_n,
  input  logic             cnt_clr,
  output logic [31:0]      sw_word,
  output logic [31:0]      key_word,
  output logic [31:0]      key_cnt_word,
  output logic [31:0]      key_evt_word
);

  localparam int               N_BIT   = N_SW + N_KEY;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0]             sw_s1_q;
  logic [N_SW-1:0]             sw_s2_q;
  logic [N_KEY-1:0]            key_s1_q;
  logic [N_KEY-1:0]            key_s2_q;
  logic [N_BIT-1:0]            lvl;
  logic [N_BIT-1:0]            stable_q;
  logic [N_BIT-1:0]            stable_d;
  logic [N_BIT-1:0][CNT_W-1:0] db_cnt_q;
  logic [N_BIT-1:0][CNT_W-1:0] db_cnt_d;
  logic [N_KEY-1:0]            evt_q;
  logic [N_KEY-1:0]            evt_d;
  logic [N_KEY-1:0][7:0]       press_cnt_q;
  logic [N_KEY-1:0][7:0]       press_cnt_d;

  // Key synchronizers reset to the released (high) pin level so that no
  // press is seen while the chain refills after reset.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
    end else begin
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= key_raw_n;
      key_s2_q <= key_s1_q;
    end
  end

  assign lvl = {~key_s2_q, sw_s2_q};

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int b = 0; b < N_BIT; b++) begin
      if (lvl[b] == stable_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == DB_LAST) begin
        stable_d[b] = lvl[b];
        db_cnt_d[b] = '0;
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + CNT_W'(1);
      end
    end
  end

  // Event is registered alongside the new stable level, so it is high in the
  // first cycle the key reads as pressed.
  assign evt_d = stable_d[N_BIT-1:N_SW] & ~stable_q[N_BIT-1:N_SW];

  always_comb begin
    press_cnt_d = press_cnt_q;
    if (cnt_clr) begin
      press_cnt_d = '0;
    end else begin
      for (int k = 0; k < N_KEY; k++) begin
        if (evt_q[k]) press_cnt_d[k] = press_cnt_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      stable_q    <= '0;
      db_cnt_q    <= '0;
      evt_q       <= '0;
      press_cnt_q <= '0;
    end else begin
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      evt_q       <= evt_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign sw_word      = 32'(stable_q[N_SW-1:0]);
  assign key_word     = 32'(stable_q[N_BIT-1:N_SW]);
  assign key_cnt_word = 32'(press_cnt_q);
  assign key_evt_word = 32'(evt_q);

endmodule

// File: tb/tb_io_input_debounce.sv
// Bench for io_input_debounce: vector table, hand-written corner sequences and
// randomized traffic, all compared against a run-length reference model.
module tb_io_input_debounce;

  localparam int N_SW  = 18;
  localparam int N_KEY = 4;
  localparam int DB    = 4;
  localparam int N_BIT = N_SW + N_KEY;

  logic              clk;
  logic              resetn;
  logic [N_SW-1:0]   sw_raw;
  logic [N_KEY-1:0]  key_raw_n;
  logic              cnt_clr;
  logic [31:0]       sw_word;
  logic [31:0]       key_word;
  logic [31:0]       key_cnt_word;
  logic [31:0]       key_evt_word;

  int errors = 0;
  int checks = 0;

  io_input_debounce #(
    .N_SW(N_SW), .N_KEY(N_KEY), .DB_CYCLES(DB), .CNT_W(3)
  ) dut (
    .io_clk(clk), .resetn(resetn), .sw_raw(sw_raw), .key_raw_n(key_raw_n),
    .cnt_clr(cnt_clr), .sw_word(sw_word), .key_word(key_word),
    .key_cnt_word(key_cnt_word), .key_evt_word(key_evt_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: level seen after two sampling edges; a level is accepted
  // once it has differed from the accepted level for DB consecutive edges.
  bit m_s1 [N_BIT];
  bit m_s2 [N_BIT];
  bit m_stable [N_BIT];
  int m_run [N_BIT];
  bit m_evt [N_KEY];
  int m_cnt [N_KEY];
  int evt_seen [N_KEY];

  function automatic void model_reset();
    for (int b = 0; b < N_BIT; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_run[b] = 0;
    end
    for (int k = 0; k < N_KEY; k++) begin
      m_evt[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < N_KEY; k++) begin
      if (cnt_clr) m_cnt[k] = 0;
      else if (m_evt[k]) m_cnt[k] = (m_cnt[k] + 1) % 256;
      m_evt[k] = 0;
    end
    for (int b = 0; b < N_BIT; b++) begin
      if (m_s2[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_stable[b] = m_s2[b];
          m_run[b] = 0;
          if (b >= N_SW && m_stable[b]) m_evt[b - N_SW] = 1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    for (int b = 0; b < N_BIT; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = (b < N_SW) ? sw_raw[b] : !key_raw_n[b - N_SW];
    end
  endfunction

  function automatic logic [31:0] exp_sw();
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < N_SW; b++) w[b] = m_stable[b];
    return w;
  endfunction

  function automatic logic [31:0] exp_key();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < N_KEY; k++) w[k] = m_stable[N_SW + k];
    return w;
  endfunction

  function automatic logic [31:0] exp_evt();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < N_KEY; k++) w[k] = m_evt[k];
    return w;
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < N_KEY; k++) w[8*k +: 8] = 8'(m_cnt[k]);
    return w;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (resetn) model_edge();
    else model_reset();
    #1;
    check("model_sw", sw_word, exp_sw());
    check("model_key", key_word, exp_key());
    check("model_evt", key_evt_word, exp_evt());
    check("model_cnt", key_cnt_word, exp_cnt());
    for (int k = 0; k < N_KEY; k++) if (key_evt_word[k] === 1'b1) evt_seen[k]++;
  endtask

  task automatic press(int k);
    key_raw_n = ~(4'b0001 << k);
    repeat (8) tick();
    key_raw_n = 4'hF;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [N_SW-1:0]  sw;
    logic [N_KEY-1:0] key_n;
    int               cycles;
    logic [31:0]      exp_sw;
    logic [31:0]      exp_key;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{18'h1, 4'hF, 5,  32'h0, 32'h0};
    vecs[1]  = '{18'h1, 4'hF, 1,  32'h1, 32'h0};
    vecs[2]  = '{18'h0, 4'hF, 5,  32'h1, 32'h0};
    vecs[3]  = '{18'h0, 4'hF, 1,  32'h0, 32'h0};
    vecs[4]  = '{18'h8, 4'hF, 3,  32'h0, 32'h0};
    vecs[5]  = '{18'h0, 4'hF, 10, 32'h0, 32'h0};
    vecs[6]  = '{18'h8, 4'hF, 3,  32'h0, 32'h0};
    vecs[7]  = '{18'h0, 4'hF, 1,  32'h0, 32'h0};
    vecs[8]  = '{18'h8, 4'hF, 5,  32'h0, 32'h0};
    vecs[9]  = '{18'h8, 4'hF, 1,  32'h8, 32'h0};
    vecs[10] = '{18'h0, 4'hF, 6,  32'h0, 32'h0};
    vecs[11] = '{18'h0, 4'hD, 20, 32'h0, 32'h2};
    vecs[12] = '{18'h0, 4'hF, 20, 32'h0, 32'h0};

    resetn = 1'b0; sw_raw = '0; key_raw_n = 4'hF; cnt_clr = 1'b0;
    model_reset();
    for (int k = 0; k < N_KEY; k++) evt_seen[k] = 0;
    repeat (2) tick();
    check("reset_sw", sw_word, 32'h0);
    check("reset_key", key_word, 32'h0);
    check("reset_cnt", key_cnt_word, 32'h0);
    check("reset_evt", key_evt_word, 32'h0);
    #2 resetn = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 13; i++) begin
      if (i == 11) for (int k = 0; k < N_KEY; k++) evt_seen[k] = 0;
      sw_raw = vecs[i].sw;
      key_raw_n = vecs[i].key_n;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_sw", i), sw_word, vecs[i].exp_sw);
      check($sformatf("vec%0d_key", i), key_word, vecs[i].exp_key);
      if (i == 11) begin
        check("key1_press_events", 32'(evt_seen[1]), 32'd1);
        check("key1_press_count", key_cnt_word, 32'h0000_0100);
      end
      if (i == 12) begin
        check("key1_release_no_event", 32'(evt_seen[1]), 32'd1);
        check("key1_count_after_release", key_cnt_word, 32'h0000_0100);
      end
    end

    repeat (255) press(0);
    check("key0_255_presses", key_cnt_word, 32'h0000_01FF);
    press(0);
    check("key0_wrap", key_cnt_word, 32'h0000_0100);

    key_raw_n = 4'hB;
    repeat (6) tick();
    check("key2_event_now", key_evt_word, 32'h4);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_beats_event", key_cnt_word, 32'h0);
    repeat (4) tick();
    key_raw_n = 4'hF;
    repeat (8) tick();
    press(2);
    check("key2_after_clear", key_cnt_word, 32'h0001_0000);

    sw_raw = 18'h1;
    repeat (8) tick();
    check("sw0_stable", sw_word, 32'h1);
    sw_raw = 18'h21;
    key_raw_n = 4'h7;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    check("midreset_sw", sw_word, 32'h0);
    check("midreset_key", key_word, 32'h0);
    check("midreset_cnt", key_cnt_word, 32'h0);
    check("midreset_evt", key_evt_word, 32'h0);
    repeat (2) tick();
    #2 resetn = 1'b1;
    repeat (5) tick();
    check("post_reset_edge5", sw_word, 32'h0);
    tick();
    check("post_reset_edge6", sw_word, 32'h21);
    check("held_key_event", key_evt_word, 32'h8);
    tick();
    check("held_key_count", key_cnt_word, 32'h0100_0000);
    key_raw_n = 4'hF;
    sw_raw = '0;
    repeat (8) tick();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = $urandom_range(0, N_SW - 1);
        sw_raw[idx] = ~sw_raw[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        int kdx;
        kdx = $urandom_range(0, N_KEY - 1);
        key_raw_n[kdx] = ~key_raw_n[kdx];
      end
      cnt_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    cnt_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
